// File: rtl/dsp_program_sequencer.sv
// dsp_program_sequencer
// Fetches instructions from a synchronous instruction memory and issues them one at a
// time to the DSP controller over its start/valid handshake. It waits for each
// instruction to retire before fetching the next one. It also provides a completion
// pulse, an abort path and a watchdog that flags a controller that stops answering.
module dsp_program_sequencer #(
    parameter int I_WIDTH  = 16,
    parameter int PC_WIDTH = 5,
    parameter int TIMEOUT  = 64,
    parameter int TO_WIDTH = 7
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                run_i,
    input  logic                abort_i,
    input  logic [PC_WIDTH:0]   prog_len_i,
    output logic                imem_re_o,
    output logic [PC_WIDTH-1:0] imem_addr_o,
    input  logic [I_WIDTH-1:0]  imem_rdata_i,
    output logic                ctrl_start_o,
    output logic [I_WIDTH-1:0]  ctrl_instr_o,
    input  logic                ctrl_valid_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [PC_WIDTH-1:0] pc_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_RD,
        S_ISSUE,
        S_RELEASE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [PC_WIDTH:0]     len_q, len_d;
    logic [TO_WIDTH-1:0]   wd_q, wd_d;
    logic [I_WIDTH-1:0]    instr_q, instr_d;
    logic                  re_q, re_d;
    logic                  start_q, start_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  is_last;
    logic                  wd_expired;
    logic                  zero_len_done;

    // Next-state logic. Every output is derived from the next state so it is registered.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        len_d         = len_q;
        wd_d          = wd_q;
        instr_d       = instr_q;
        err_d         = err_q;
        zero_len_done = 1'b0;
        // Exact compare against the last index: pc never has to wrap to find the end.
        is_last       = ({1'b0, pc_q} == (len_q - 1'b1));
        wd_expired    = (wd_q == TO_WIDTH'(TIMEOUT - 1));

        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            pc_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run_i) begin
                        if (prog_len_i != '0) begin
                            len_d   = prog_len_i;
                            pc_d    = '0;
                            err_d   = 1'b0;
                            state_d = S_FETCH;
                        end else begin
                            zero_len_done = 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    state_d = S_WAIT_RD;
                end
                S_WAIT_RD: begin
                    instr_d = imem_rdata_i;
                    wd_d    = '0;
                    state_d = S_ISSUE;
                end
                S_ISSUE: begin
                    wd_d = wd_q + 1'b1;
                    // A valid that arrives on the expiry cycle still counts as an answer.
                    if (ctrl_valid_i) begin
                        state_d = S_RELEASE;
                    end else if (wd_expired) begin
                        state_d = S_ERROR;
                    end
                end
                S_RELEASE: begin
                    wd_d = wd_q + 1'b1;
                    if (!ctrl_valid_i) begin
                        if (is_last) begin
                            state_d = S_DONE;
                        end else begin
                            pc_d    = pc_q + 1'b1;
                            state_d = S_FETCH;
                        end
                    end else if (wd_expired) begin
                        state_d = S_ERROR;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ERROR: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        if (state_d == S_ERROR) begin
            err_d = 1'b1;
        end
        re_d    = (state_d == S_FETCH);
        start_d = (state_d == S_ISSUE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE) || zero_len_done;
    end

    // State and output registers. A reset clears everything, including the held instruction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            wd_q    <= '0;
            instr_q <= '0;
            re_q    <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            wd_q    <= wd_d;
            instr_q <= instr_d;
            re_q    <= re_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign imem_re_o    = re_q;
    assign imem_addr_o  = pc_q;
    assign ctrl_start_o = start_q;
    assign ctrl_instr_o = instr_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign pc_o         = pc_q;

endmodule

// File: tb/tb_dsp_program_sequencer.sv
// Bench for dsp_program_sequencer: behavioural instruction memory and controller,
// a table of whole-program vectors, and hand-written multi-cycle corner sequences.
module tb_dsp_program_sequencer;

    localparam int IW = 16;
    localparam int PW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          abort = 1'b0;
    logic [PW:0]   prog_len = '0;
    logic          imem_re;
    logic [PW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata = '0;
    logic          ctrl_start;
    logic [IW-1:0] ctrl_instr;
    logic          ctrl_valid = 1'b0;
    logic          busy;
    logic          done;
    logic          err;
    logic [PW-1:0] pc;

    dsp_program_sequencer #(
        .I_WIDTH (IW),
        .PC_WIDTH(PW),
        .TIMEOUT (64),
        .TO_WIDTH(7)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .run_i       (run),
        .abort_i     (abort),
        .prog_len_i  (prog_len),
        .imem_re_o   (imem_re),
        .imem_addr_o (imem_addr),
        .imem_rdata_i(imem_rdata),
        .ctrl_start_o(ctrl_start),
        .ctrl_instr_o(ctrl_instr),
        .ctrl_valid_i(ctrl_valid),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .pc_o        (pc)
    );

    always #5 clk = ~clk;

    // Instruction memory: one-cycle read latency.
    logic [IW-1:0] imem [32];
    always @(posedge clk) begin
        if (imem_re) imem_rdata <= imem[imem_addr];
    end

    // Controller: valid rises lat cycles after start is seen, falls once start drops.
    int ctrl_lat  = 12;
    bit ctrl_dead = 1'b0;
    int ccnt = 0;
    always @(posedge clk) begin
        if (rst || ctrl_dead) begin
            ctrl_valid <= 1'b0;
            ccnt       <= 0;
        end else if (ctrl_start && !ctrl_valid) begin
            if (ccnt >= ctrl_lat - 1) ctrl_valid <= 1'b1;
            else                      ccnt <= ccnt + 1;
        end else if (!ctrl_start) begin
            ctrl_valid <= 1'b0;
            ccnt       <= 0;
        end
    end

    // Monitor on the falling edge: event counters and a log of each issued instruction.
    int            done_cnt = 0, re_cnt = 0, start_cyc = 0, start_rise = 0;
    logic          start_prev = 1'b0;
    logic [IW-1:0] ilog [512];
    logic [PW-1:0] plog [512];
    always @(negedge clk) begin
        if (done)       done_cnt  <= done_cnt + 1;
        if (imem_re)    re_cnt    <= re_cnt + 1;
        if (ctrl_start) start_cyc <= start_cyc + 1;
        if (ctrl_start && !start_prev) begin
            if (start_rise < 512) begin
                ilog[start_rise] <= ctrl_instr;
                plog[start_rise] <= pc;
            end
            start_rise <= start_rise + 1;
        end
        start_prev <= ctrl_start;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int len);
        prog_len = len[PW:0];
        run      = 1'b1;
        tick();
        run      = 1'b0;
    endtask

    task automatic wait_done(input int limit, inout int cycles);
        while (!done && cycles < limit) begin
            tick();
            cycles++;
        end
    endtask

    typedef struct {
        int len;
        int lat;
        int exp_cycles;
        int exp_starts;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int cycles;
        int b_done, b_re, b_rise, b_cyc;
        bit found;

        for (int i = 0; i < 32; i++) imem[i] = 16'((i * 313) ^ 16'hC3A5);

        // Run edge counts as cycle 1; each instruction takes lat + 5 cycles.
        tbl[0] = '{3, 12, 52, 3};
        tbl[1] = '{1, 1, 7, 1};
        tbl[2] = '{2, 3, 17, 2};
        tbl[3] = '{0, 4, 1, 0};
        tbl[4] = '{32, 1, 193, 32};

        // ---- power-on reset
        repeat (3) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_start", int'(ctrl_start), 0);
        check("rst_re", int'(imem_re), 0);
        check("rst_pc", int'(pc), 0);
        rst = 1'b0;
        tick();

        // ---- table-driven whole programs
        for (int v = 0; v < 5; v++) begin
            ctrl_lat = tbl[v].lat;
            b_done = done_cnt; b_re = re_cnt; b_rise = start_rise;
            start_run(tbl[v].len);
            cycles = 1;
            wait_done(400, cycles);
            check($sformatf("v%0d_cycles", v), cycles, tbl[v].exp_cycles);
            check($sformatf("v%0d_done", v), int'(done), 1);
            check($sformatf("v%0d_busy_in_done", v), int'(busy), (tbl[v].len != 0) ? 1 : 0);
            check($sformatf("v%0d_starts", v), start_rise - b_rise, tbl[v].exp_starts);
            check($sformatf("v%0d_reads", v), re_cnt - b_re, tbl[v].exp_starts);
            for (int i = 0; i < tbl[v].len; i++) begin
                check($sformatf("v%0d_instr%0d", v, i), int'(ilog[b_rise + i]), int'(imem[i]));
                check($sformatf("v%0d_pc%0d", v, i), int'(plog[b_rise + i]), i);
            end
            tick();
            check($sformatf("v%0d_done_drop", v), int'(done), 0);
            check($sformatf("v%0d_busy_drop", v), int'(busy), 0);
            check($sformatf("v%0d_done_pulses", v), done_cnt - b_done, 1);
            tick();
        end

        // ---- run_i held high: one run, next run starts from IDLE after done
        ctrl_lat = 2;
        b_done = done_cnt; b_re = re_cnt;
        prog_len = 6'd2;
        run = 1'b1;
        tick();
        cycles = 1;
        wait_done(200, cycles);
        check("hold_cycles", cycles, 15);
        check("hold_reads", re_cnt - b_re, 2);
        tick();
        check("hold_idle_busy", int'(busy), 0);
        check("hold_idle_re", int'(imem_re), 0);
        check("hold_done_pulses", done_cnt - b_done, 1);
        tick();
        check("hold_rerun_re", int'(imem_re), 1);
        check("hold_rerun_busy", int'(busy), 1);
        check("hold_rerun_pc", int'(pc), 0);
        run = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("hold_abort_busy", int'(busy), 0);
        tick();

        // ---- watchdog: controller never answers
        ctrl_dead = 1'b1;
        b_done = done_cnt; b_re = re_cnt; b_cyc = start_cyc;
        start_run(2);
        cycles = 1;
        while (!err && cycles < 200) begin
            tick();
            cycles++;
        end
        check("wd_cycles", cycles, 67);
        check("wd_err", int'(err), 1);
        check("wd_start", int'(ctrl_start), 0);
        check("wd_busy", int'(busy), 1);
        check("wd_issue_cycles", start_cyc - b_cyc, 64);
        tick();
        check("wd_busy_drop", int'(busy), 0);
        repeat (3) tick();
        check("wd_err_sticky", int'(err), 1);
        check("wd_reads", re_cnt - b_re, 1);
        check("wd_no_done", done_cnt - b_done, 0);
        ctrl_dead = 1'b0;
        ctrl_lat = 1;
        start_run(1);
        check("wd_err_cleared", int'(err), 0);
        cycles = 1;
        wait_done(100, cycles);
        check("wd_rerun_done", int'(done), 1);
        repeat (2) tick();

        // ---- abort during RELEASE of instruction 1 of 4
        ctrl_lat = 12;
        b_done = done_cnt;
        start_run(4);
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            if (pc == 5'd1 && ctrl_valid && !ctrl_start) found = 1'b1;
            else tick();
        end
        check("abort_reached_release", int'(found), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        b_re = re_cnt;
        check("abort_busy", int'(busy), 0);
        check("abort_start", int'(ctrl_start), 0);
        check("abort_re", int'(imem_re), 0);
        check("abort_pc", int'(pc), 0);
        check("abort_done", int'(done), 0);
        repeat (20) tick();
        check("abort_no_reads", re_cnt - b_re, 0);
        check("abort_no_done", done_cnt - b_done, 0);
        check("abort_err", int'(err), 0);

        // ---- synchronous reset held 3 cycles mid-ISSUE
        start_run(3);
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (ctrl_start) found = 1'b1;
            else tick();
        end
        check("mid_reached_issue", int'(found), 1);
        rst = 1'b1;
        repeat (3) tick();
        check("mid_busy", int'(busy), 0);
        check("mid_start", int'(ctrl_start), 0);
        check("mid_re", int'(imem_re), 0);
        check("mid_done", int'(done), 0);
        check("mid_err", int'(err), 0);
        check("mid_pc", int'(pc), 0);
        check("mid_addr", int'(imem_addr), 0);
        check("mid_instr", int'(ctrl_instr), 0);
        rst = 1'b0;
        repeat (2) tick();
        check("mid_stays_idle", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
